// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_resp data-memory responder.
// Supplies a 64-bit CPU_WIDTH when the global define is absent.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [63:0] DMEM_BASE_ADDR = 64'h0000_0000_8000_0000;

    // Moves byte lane 'off' down to lane 0, zero-filling the top.
    function automatic logic [63:0] lane_shift_right(input logic [63:0] word,
                                                     input logic [2:0]  off);
        return word >> {off, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 64-bit storage with per-byte write enables and a combinational read.
// Contents are never reset.
module dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic [7:0]    i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < 8; b++) begin
            if (i_we[b]) begin
                mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = mem[i_idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: single outstanding load/store, fixed-latency response.
// Optional DMEM_MISALIGN_ERR_EN flags stores whose byte lanes run past lane 7.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = DMEM_BASE_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [`CPU_WIDTH-1:0] i_req_addr,
    input  logic [`CPU_WIDTH-1:0] i_req_wdata,
    input  logic [7:0]            i_req_wmask,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [`CPU_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int unsigned XLEN = `CPU_WIDTH;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [63:0]     addr64, offs, wdata64, wdata_sh, ram_rdata;
    logic [2:0]      off;
    logic [AW-1:0]   idx;
    logic [7:0]      lane_en, ram_we;
    logic            range_err, misalign_err, accept, rsp_hs;

    assign addr64    = 64'(i_req_addr);
    assign wdata64   = 64'(i_req_wdata);
    assign off       = addr64[2:0];
    assign offs      = addr64 - BASE_ADDR;
    assign range_err = (addr64 < BASE_ADDR) || (offs >= SPAN);
    assign idx       = offs[AW+2:3];
    assign wdata_sh  = wdata64 << {off, 3'b000};

`ifdef DMEM_MISALIGN_ERR_EN
    logic [15:0] lane_wide;
    assign lane_wide    = {8'h00, i_req_wmask} << off;
    assign lane_en      = lane_wide[7:0];
    assign misalign_err = i_req_wen && (|lane_wide[15:8]);
`else
    // Narrow shift discards lanes that would land beyond byte 7.
    assign lane_en      = i_req_wmask << off;
    assign misalign_err = 1'b0;
`endif

    assign accept = i_req_valid && o_req_ready;
    assign rsp_hs = o_rsp_valid && i_rsp_ready;
    assign ram_we = (accept && i_req_wen && !range_err && !misalign_err) ? lane_en : '0;

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_idx   (idx),
        .i_wdata (wdata_sh),
        .o_rdata (ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q   <= range_err || misalign_err;
                rdata_q <= (!i_req_wen && !range_err)
                           ? XLEN'(lane_shift_right(ram_rdata, off)) : '0;
            end else if (rsp_hs) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q == 4'(LATENCY - 1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule
